// File: rtl/sram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-cycle-addressed
// asynchronous SRAM. Every access is a fixed WAIT_CYCLES window followed by a one-cycle DONE.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 4,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [31:0]        i_addr,
  output logic [31:0]        i_rdata,
  output logic               i_ready,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  output logic [31:0]        d_rdata,
  output logic               d_ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic [1:0]         grant,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [3:0] CNT_LOAD  = 4'(WAIT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         grant_q, grant_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        i_rdata_q, i_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               last_data_q, last_data_d;
  logic               pick_data;
  logic [31:0]        sel_addr;

  // Data wins when it is alone, or when both ask and instr was served last.
  assign pick_data = d_req && (!i_req || !last_data_q);
  assign sel_addr  = pick_data ? d_addr : i_addr;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    last_data_d = last_data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_LOAD;
          grant_d = pick_data ? 2'b10 : 2'b01;
          addr_d  = SRAM_AW'((sel_addr - 32'(BASE_ADDR)) >> 2);
          we_d    = pick_data && d_we;
          if (pick_data) wdata_d = d_wdata;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (grant_q[0]) i_rdata_d = sram_dq_in;
            else            d_rdata_d = sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        grant_d     = 2'b00;
        last_data_d = grant_q[1];
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      grant_q     <= 2'b00;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
      last_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      last_data_q <= last_data_d;
    end
  end

  // Write enable releases one cycle early so data is held past the we_n rising edge.
  assign sram_ce_n   = (state_q != ST_ACCESS);
  assign sram_we_n   = !((state_q == ST_ACCESS) && we_q && (cnt_q != 4'd0));
  assign sram_dq_oe  = (state_q == ST_ACCESS) && we_q;
  assign sram_dq_out = wdata_q;
  assign sram_addr   = addr_q;
  assign grant       = grant_q;
  assign busy        = (state_q != ST_IDLE);
  assign i_ready     = (state_q == ST_DONE) && grant_q[0];
  assign d_ready     = (state_q == ST_DONE) && grant_q[1];
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized two-port bench for sram_arbiter: per-port drivers push expectations,
// a negedge monitor checks bus protocol, arbitration, latency and read data.
module tb_sram_arbiter;

  localparam int WAIT = 4;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic [31:0] i_rdata, d_rdata, sram_dq_out, sram_dq_in;
  logic        i_ready, d_ready, sram_dq_oe, sram_ce_n, sram_we_n, busy;
  logic [15:0] sram_addr;
  logic [1:0]  grant;

  sram_arbiter #(.WAIT_CYCLES(WAIT), .BASE_ADDR(BASE), .SRAM_AW(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic [15:0] word;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sram_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, ~a} + 32'h0101_0101;
  endfunction

  // SRAM model: read data only valid in the last cycle of a chip-enabled window.
  int sram_cnt = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst)           sram_cnt <= 0;
    else if (!sram_ce_n) sram_cnt <= sram_cnt + 1;
    else                sram_cnt <= 0;
  end
  always_comb begin
    sram_dq_in = 32'h0BAD_F00D;
    if (!sram_ce_n && sram_we_n && sram_cnt == WAIT - 1) sram_dq_in = sram_word(sram_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        inflight = 1'b0, cur_d = 1'b0, last_data = 1'b0;
  logic        prev_any = 1'b0, prev_both = 1'b0, prev_d = 1'b0;
  logic [1:0]  prev_grant = 2'b00, exp_g;
  logic [31:0] m_i = 32'h0, m_d = 32'h0;
  int          g_cyc = 0, acc_cnt = 0, qn;
  txn_t        cur;

  always @(negedge clk) begin
    if (!rst) begin
      inflight = 1'b0; acc_cnt = 0; last_data = 1'b0;
      m_i = 32'h0; m_d = 32'h0;
      prev_any = 1'b0; prev_both = 1'b0; prev_d = 1'b0; prev_grant = 2'b00;
    end else begin
      if (prev_grant == 2'b00 && grant != 2'b00) begin
        check("grant_had_req", 32'(prev_any), 32'd1);
        if (prev_both) exp_g = last_data ? 2'b01 : 2'b10;
        else           exp_g = prev_d ? 2'b10 : 2'b01;
        check("grant_winner", 32'(grant), 32'(exp_g));
        cur_d = grant[1];
        qn = cur_d ? dq.size() : iq.size();
        check("grant_pending_txn", 32'(qn > 0), 32'd1);
        if (qn > 0) begin
          cur = cur_d ? dq[0] : iq[0];
          inflight = 1'b1; g_cyc = cyc; acc_cnt = 0;
        end
      end else if (prev_grant == 2'b00 && prev_any) begin
        check("req_not_granted", 32'(grant != 2'b00), 32'd1);
      end

      if (!sram_ce_n) begin
        check("ce_in_txn", 32'(inflight), 32'd1);
        if (inflight) begin
          acc_cnt++;
          check("sram_addr", 32'(sram_addr), 32'(cur.word));
          check("sram_oe", 32'(sram_dq_oe), 32'(cur.we));
          check("sram_we_n", 32'(sram_we_n), 32'(!(cur.we && acc_cnt < WAIT)));
          if (cur.we) check("sram_dq_out", sram_dq_out, cur.wdata);
        end
      end

      if (i_ready || d_ready) begin
        check("ready_in_txn", 32'(inflight), 32'd1);
        if (inflight) begin
          check("ready_port", 32'({d_ready, i_ready}), 32'(grant));
          check("ready_latency", 32'(cyc - g_cyc), 32'(WAIT));
          check("access_cycles", 32'(acc_cnt), 32'(WAIT));
          check("done_ce_n", 32'(sram_ce_n), 32'd1);
          if (cur_d) void'(dq.pop_front());
          else       void'(iq.pop_front());
          if (!cur.we) begin
            if (cur_d) m_d = sram_word(cur.word);
            else       m_i = sram_word(cur.word);
          end
          $display("[TB] %s %s word=%h wdata=%h cyc=%0d", cur_d ? "data" : "inst",
                   cur.we ? "WR" : "RD", cur.word, cur.wdata, cyc);
          last_data = cur_d;
          inflight = 1'b0;
        end
      end

      if (!busy)
        check("idle_outputs", 32'({sram_ce_n, sram_we_n, sram_dq_oe, grant, i_ready, d_ready}),
              32'(7'b1100000));
      check("busy_vs_grant", 32'(busy), 32'(grant != 2'b00));
      check("i_rdata", i_rdata, m_i);
      check("d_rdata", d_rdata, m_d);

      prev_grant = grant;
      prev_any   = !busy && (i_req || d_req);
      prev_both  = !busy && i_req && d_req;
      prev_d     = d_req;
    end
  end

  // ---------------- drivers ----------------
  task automatic run_port(input bit is_d, input int n);
    int          gap, word;
    logic [31:0] addr;
    logic        we, got, scr;
    txn_t        e;
    for (int k = 0; k < n; k++) begin
      gap = (k == 0) ? 0 : $urandom_range(0, 3);
      if (gap > 0) begin
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      word = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) addr = BASE - 4 * $urandom_range(1, 4);
      else                           addr = BASE + 4 * word;
      we = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      e.we = we; e.wdata = $urandom; e.word = 16'((addr - BASE) >> 2);
      if (is_d) begin
        d_addr = addr; d_we = we; d_wdata = e.wdata; dq.push_back(e); d_req = 1'b1;
      end else begin
        i_addr = addr; iq.push_back(e); i_req = 1'b1;
      end
      got = 1'b0; scr = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(posedge clk); #1;
        if (!scr && (is_d ? grant[1] : grant[0])) begin
          scr = 1'b1;
          if (is_d) begin d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we; end
          else      i_addr = $urandom;
        end
        if (is_d ? d_ready : i_ready) begin got = 1'b1; break; end
      end
      check(is_d ? "d_timeout" : "i_timeout", 32'(got), 32'd1);
    end
    if (is_d) begin d_req = 1'b0; d_we = 1'b0; end
    else      i_req = 1'b0;
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk); #1; rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    logic got;
    txn_t e;
    #2 rst = 1'b0;
    #1;
    check("rst_ctrl", 32'({sram_ce_n, sram_we_n, sram_dq_oe, grant, busy, i_ready, d_ready}),
          32'(8'b1100_0000));
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", sram_dq_out, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Write aborted by reset during its second access cycle, then restarted.
    @(posedge clk); #1;
    e.we = 1'b1; e.wdata = 32'hDEAD_BEEF; e.word = 16'd3;
    dq.push_back(e);
    d_addr = 32'd1036; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1;
    n = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (!sram_ce_n) n++;
      if (n == 2) break;
    end
    check("reached_2nd_access", 32'(n), 32'd2);
    #3 rst = 1'b0;
    #1;
    check("abort_ctrl", 32'({sram_ce_n, sram_we_n, sram_dq_oe, grant, busy, d_ready}),
          32'(7'b1100000));
    check("abort_sram_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (d_ready) begin got = 1'b1; break; end
    end
    check("restart_done", 32'(got), 32'd1);
    d_req = 1'b0; d_we = 1'b0;

    // Fresh reset so both ports requesting together see data win first.
    pulse_reset(2);
    @(posedge clk); #1;
    fork
      run_port(1'b0, 40);
      run_port(1'b1, 40);
    join
    repeat (10) @(posedge clk);
    #1;
    check("iq_drained", 32'(iq.size()), 32'd0);
    check("dq_drained", 32'(dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
